uart_tx_feeder: RTL

- Synchronous FIFO plus launch controller that sits directly upstream of the UART TX control FSM.
- Buffers parallel words written by the host side.
- Presents one word at a time on P_DATA with a single-cycle DATA_VALID pulse.
- Uses the FSM's registered BUSY flag to pace launches, so back-to-back host writes never collide with a frame in progress.

---
 rtl/uart_tx_feeder_if.sv | 43 ++++
 rtl/uart_tx_feeder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder_if
//  Brief    : Host-write / TX-launch bundle for uart_tx_feeder. The OVERFLOW
//             and OVF_CLR pair exists only with UART_TX_FEEDER_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_W      = 3
);
    logic                  WR_EN;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  FULL;
    logic                  EMPTY;
    logic [PTR_W:0]        COUNT;
    logic                  TX_BUSY;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
`ifdef UART_TX_FEEDER_OVF_EN
    logic                  OVERFLOW;
    logic                  OVF_CLR;

    modport master (
        output WR_EN, WR_DATA, TX_BUSY, OVF_CLR,
        input  FULL, EMPTY, COUNT, P_DATA, DATA_VALID, OVERFLOW
    );
    modport slave (
        input  WR_EN, WR_DATA, TX_BUSY, OVF_CLR,
        output FULL, EMPTY, COUNT, P_DATA, DATA_VALID, OVERFLOW
    );
`else
    modport master (
        output WR_EN, WR_DATA, TX_BUSY,
        input  FULL, EMPTY, COUNT, P_DATA, DATA_VALID
    );
    modport slave (
        input  WR_EN, WR_DATA, TX_BUSY,
        output FULL, EMPTY, COUNT, P_DATA, DATA_VALID
    );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Brief    : FIFO plus launch controller pacing words into a UART TX FSM via
//             its registered BUSY flag. Optional sticky drop flag is enabled by
//             defining UART_TX_FEEDER_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3,
    parameter int BUSY_TO    = 4
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_feeder_if.slave fif
);
    localparam int c_CNT_W = PTR_W + 1;
    localparam int c_TO_W  = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [PTR_W-1:0]   c_PTR_ONE = PTR_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(BUSY_TO - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_TO_W-1:0]     r_to_cnt;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // The only pop is the IDLE->LAUNCH edge, so a full FIFO can accept a word there.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !fif.TX_BUSY;
    assign w_push  = fif.WR_EN && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fif.WR_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_data_valid <= 1'b0;
            r_p_data     <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state      <= S_LAUNCH;
                        r_data_valid <= 1'b1;
                        r_p_data     <= r_mem[r_rd_ptr];
                    end
                end
                S_LAUNCH: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A TX that never acknowledges still consumes the word.
                    if (fif.TX_BUSY) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!fif.TX_BUSY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic w_drop;
    logic r_overflow;

    assign w_drop = fif.WR_EN && w_full && !w_pop;

    // Set has priority so a drop coinciding with a clear is never lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (fif.OVF_CLR) begin
            r_overflow <= 1'b0;
        end
    end

    assign fif.OVERFLOW = r_overflow;
`endif

    assign fif.FULL       = w_full;
    assign fif.EMPTY      = w_empty;
    assign fif.COUNT      = r_count;
    assign fif.P_DATA     = r_p_data;
    assign fif.DATA_VALID = r_data_valid;

endmodule
`default_nettype wire
